// File: rtl/palette_pkg.sv
// palette_pkg: colour type, default palette contents and flash-state encoding
package palette_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

  typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_e;

  localparam color_t FLASH_COLOR = 12'hFFF;

  localparam color_t DEFAULT_PALETTE [8] = '{
    12'h0E1, 12'h070, 12'hECA, 12'h05E, 12'hE30, 12'h643, 12'h000, 12'h028
  };

  // Only bank 0 carries the default palette; everything else powers up black.
  function automatic color_t default_color(input int unsigned bank, input int unsigned idx);
    logic [2:0] sel;
    sel = idx[2:0];
    return (bank == 0 && idx < 8) ? DEFAULT_PALETTE[sel] : color_t'(12'h000);
  endfunction
endpackage

// File: rtl/palette_bank_ram.sv
// palette_bank_ram: banked palette storage, one write port, one registered read port,
// contents reloaded with the default palette on reset.
module palette_bank_ram
  import palette_pkg::*;
#(
  parameter int IDX_W     = 3,
  parameter int NUM_BANKS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rd_en_i,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank_i,
  input  logic [IDX_W-1:0]             rd_addr_i,
  output color_t                       rd_data_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank_i,
  input  logic [IDX_W-1:0]             wr_addr_i,
  input  color_t                       wr_data_i
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int N     = NUM_BANKS * DEPTH;

  color_t mem_q [N];
  color_t rd_q;

  // Read samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) mem_q[i] <= default_color(i / DEPTH, i % DEPTH);
      rd_q <= '0;
    end else begin
      if (wr_en_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      if (rd_en_i) rd_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end

  assign rd_data_o = rd_q;
endmodule

// File: rtl/sprite_palette_ctrl.sv
// sprite_palette_ctrl: registered palette lookup with vsync-shadowed bank select
// and a frame-counted hit-flash effect.
module sprite_palette_ctrl
  import palette_pkg::*;
#(
  parameter int IDX_W      = 3,
  parameter int NUM_BANKS  = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         pix_valid,
  input  logic [IDX_W-1:0]             index,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_req,
  input  logic                         vsync_pulse,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [IDX_W-1:0]             wr_addr,
  input  logic [11:0]                  wr_data,
  input  logic                         flash_req,
  input  logic [3:0]                   flash_frames,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic                         out_valid,
  output logic                         transparent,
  output logic                         flashing
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  flash_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BANK_W-1:0] bank_q;
  logic              valid_q, transp_q, ovr_q, flashing_q;
  logic              hit;
  color_t            rd_data;

  palette_bank_ram #(.IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS)) u_ram (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .rd_en_i   (pix_valid),
    .rd_bank_i (bank_q),
    .rd_addr_i (index),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data)
  );

  assign hit = index == IDX_W'(TRANSP_IDX);

  // A new request outranks a coincident vsync; a zero-frame request is a no-op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flash_req && flash_frames != 4'd0) begin
      state_d = FLASH_ON;
      cnt_d   = flash_frames;
    end else if (vsync_pulse && state_q != IDLE) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_d == 4'd0) ? IDLE : (state_q == FLASH_ON ? FLASH_OFF : FLASH_ON);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      valid_q    <= 1'b0;
      transp_q   <= 1'b0;
      ovr_q      <= 1'b0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flashing_q <= state_d != IDLE;
      valid_q    <= pix_valid;
      if (vsync_pulse) bank_q <= bank_req;
      if (pix_valid) begin
        transp_q <= hit;
        ovr_q    <= state_q == FLASH_ON && !hit;
      end
    end

  // RAM read register and the override flag both only move on a lookup, so the colour holds otherwise.
  assign {red, green, blue} = ovr_q ? FLASH_COLOR : rd_data;
  assign out_valid          = valid_q;
  assign transparent        = transp_q;
  assign flashing           = flashing_q;
endmodule

// File: tb/tb_sprite_palette_ctrl.sv
// tb_sprite_palette_ctrl: directed vectors against hand-computed palette and flash results.
module tb_sprite_palette_ctrl;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid, vsync_pulse, wr_en, flash_req;
  logic [2:0]  index, wr_addr;
  logic [1:0]  bank_req, wr_bank;
  logic [11:0] wr_data;
  logic [3:0]  flash_frames;
  logic [3:0]  red, green, blue;
  logic        out_valid, transparent, flashing;
  int          checks = 0;
  int          failures = 0;

  sprite_palette_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .index(index),
    .bank_req(bank_req), .vsync_pulse(vsync_pulse), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .flash_req(flash_req), .flash_frames(flash_frames),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .transparent(transparent), .flashing(flashing)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic look(input logic [2:0] idx);
    pix_valid = 1'b1;
    index     = idx;
  endtask

  initial begin
    Reset_n = 1'b0; pix_valid = 0; vsync_pulse = 0; wr_en = 0; flash_req = 0;
    index = 0; wr_addr = 0; bank_req = 0; wr_bank = 0; wr_data = 0; flash_frames = 0;
    cyc(); cyc();
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_transp", transparent, 1'b0);
    chk("rst_flash", flashing, 1'b0);
    Reset_n = 1'b1;

    look(3'd2); cyc();
    chk("lk2_valid", out_valid, 1'b1);
    chk("lk2_rgb", {red, green, blue}, 12'hECA);
    chk("lk2_transp", transparent, 1'b0);
    look(3'd0); cyc();
    chk("lk0_rgb", {red, green, blue}, 12'h0E1);
    chk("lk0_transp", transparent, 1'b1);
    pix_valid = 0; index = 3'd3; cyc();
    chk("hold_valid", out_valid, 1'b0);
    chk("hold_rgb", {red, green, blue}, 12'h0E1);
    chk("hold_transp", transparent, 1'b1);

    wr_en = 1; wr_bank = 2'd1; wr_addr = 3'd3; wr_data = 12'h123; bank_req = 2'd1; cyc();
    wr_en = 0; look(3'd3); cyc();
    chk("shadow_old", {red, green, blue}, 12'h05E);
    pix_valid = 0; vsync_pulse = 1; cyc();
    vsync_pulse = 0; look(3'd3); cyc();
    chk("shadow_new", {red, green, blue}, 12'h123);
    pix_valid = 0; bank_req = 2'd0; vsync_pulse = 1; cyc();
    vsync_pulse = 0;

    wr_en = 1; wr_bank = 2'd0; wr_addr = 3'd4; wr_data = 12'hABC; look(3'd4); cyc();
    chk("rbw_old", {red, green, blue}, 12'hE30);
    wr_en = 0; cyc();
    chk("rbw_new", {red, green, blue}, 12'hABC);

    pix_valid = 0; flash_req = 1; flash_frames = 4'd3; cyc();
    chk("fl_start", flashing, 1'b1);
    flash_req = 0; look(3'd5); cyc();
    chk("fl_on1", {red, green, blue}, 12'hFFF);
    vsync_pulse = 1; cyc();
    chk("fl_on1b", {red, green, blue}, 12'hFFF);
    vsync_pulse = 0; cyc();
    chk("fl_off", {red, green, blue}, 12'h643);
    chk("fl_off_flag", flashing, 1'b1);
    vsync_pulse = 1; cyc();
    vsync_pulse = 0; cyc();
    chk("fl_on2", {red, green, blue}, 12'hFFF);
    vsync_pulse = 1; cyc();
    chk("fl_end_flag", flashing, 1'b0);
    vsync_pulse = 0; cyc();
    chk("fl_idle", {red, green, blue}, 12'h643);

    pix_valid = 0; flash_req = 1; flash_frames = 4'd0; cyc();
    chk("fl_zero", flashing, 1'b0);
    flash_frames = 4'd1; cyc();
    flash_req = 0; look(3'd0); cyc();
    chk("fl_transp_rgb", {red, green, blue}, 12'h0E1);
    chk("fl_transp", transparent, 1'b1);
    pix_valid = 0; vsync_pulse = 1; flash_req = 1; flash_frames = 4'd2; cyc();
    chk("fl_restart", flashing, 1'b1);
    vsync_pulse = 0; flash_req = 0; look(3'd5); cyc();
    chk("fl_restart_rgb", {red, green, blue}, 12'hFFF);
    pix_valid = 0; vsync_pulse = 1; cyc();
    chk("fl_reload_cnt", flashing, 1'b1);
    cyc();
    chk("fl_reload_end", flashing, 1'b0);
    vsync_pulse = 0;

    wr_en = 1; wr_bank = 2'd0; wr_addr = 3'd1; wr_data = 12'hFFF;
    flash_req = 1; flash_frames = 4'd5; cyc();
    chk("mid_flash", flashing, 1'b1);
    #1 Reset_n = 1'b0;
    #1 chk("async_rst_flash", flashing, 1'b0);
    chk("async_rst_valid", out_valid, 1'b0);
    wr_en = 0; flash_req = 0; cyc();
    Reset_n = 1'b1; look(3'd1); cyc();
    chk("post_rst_rgb", {red, green, blue}, 12'h070);
    chk("post_rst_flash", flashing, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
